glitchfree_case_mux: RTL

//  Registered NCH-way, WIDTH-bit case mux. Select changes go through a

---
 rtl/glitchfree_case_mux.sv | 129 ++++++++++++
 1 files changed

// File: rtl/glitchfree_case_mux.sv
// Registered NCH-way case mux with handshaked select changes and a hold window.
// Optional `CASE_MUX_AND_MODE_EN` adds and_mode: AND of current and next channel.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   data_in      NCH channels, channel k = data_in[k*WIDTH +: WIDTH]
//   and_mode     (CASE_MUX_AND_MODE_EN only) AND current with next channel
//   sel_req      requested channel, qualified by sel_valid
//   sel_ready    high in IDLE; request accepted when valid & ready
//   mux_out      registered output, frozen while switching
//   cur_sel      channel currently driving mux_out
//   switching    high while the hold window runs
//   sel_err      one-cycle pulse when an out-of-range request is accepted
module glitchfree_case_mux #(
  parameter int WIDTH  = 1,
  parameter int NCH    = 4,
  parameter int SEL_W  = $clog2(NCH),
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] data_in,
`ifdef CASE_MUX_AND_MODE_EN
  input  logic                 and_mode,
`endif
  input  logic [SEL_W-1:0]     sel_req,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  output logic [WIDTH-1:0]     mux_out,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 switching,
  output logic                 sel_err
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W:0] NCH_L = (SEL_W + 1)'(NCH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  pend_q, pend_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [WIDTH-1:0]  mux_q, mux_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  ch [NCH];
  logic [WIDTH-1:0]  sel_data;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch[k] = data_in[k*WIDTH +: WIDTH];
  end

`ifdef CASE_MUX_AND_MODE_EN
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NCH - 1);
  logic [SEL_W-1:0] nxt_sel;

  // Neighbour channel wraps from NCH-1 back to 0.
  assign nxt_sel = (cur_sel_q == LAST) ? '0 : cur_sel_q + 1'b1;

  always_comb begin
    sel_data = ch[cur_sel_q];
    if (and_mode) sel_data = ch[cur_sel_q] & ch[nxt_sel];
  end
`else
  assign sel_data = ch[cur_sel_q];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    cur_sel_d = cur_sel_q;
    mux_d     = mux_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        mux_d = sel_data;
        if (sel_valid) begin
          if ({1'b0, sel_req} >= NCH_L) begin
            err_d = 1'b1;
          end else if (sel_req != cur_sel_q) begin
            pend_d  = sel_req;
            cnt_d   = CNT_INIT;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cur_sel_d = pend_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      cur_sel_q <= '0;
      mux_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      cur_sel_q <= cur_sel_d;
      mux_q     <= mux_d;
      err_q     <= err_d;
    end
  end

  // Held low during reset so no request is seen as accepted there.
  assign sel_ready = (state_q == IDLE) & rst_n;
  assign switching = (state_q == HOLD);
  assign mux_out   = mux_q;
  assign cur_sel   = cur_sel_q;
  assign sel_err   = err_q;

endmodule
